// File: rtl/assoc_cache.sv
// N-way set-associative read cache between the CPU bus and the SDRAM burst port.
// Reads allocate and fill a whole line critical-word-first. Writes update hitting
// lines byte by byte and never allocate. A flush (or reset) sweeps all valid state.
module assoc_cache #(
    parameter int ADDR_BITS  = 26,
    parameter int WAYS       = 2,
    parameter int SET_BITS   = 8,
    parameter int BURST_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 ready,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic                 cpu_req,
    input  logic                 cpu_rw_n,
    input  logic                 cpu_rwu_n,
    input  logic                 cpu_rwl_n,
    input  logic [15:0]          data_from_cpu,
    output logic [15:0]          data_to_cpu,
    output logic                 cpu_ack,
    output logic                 cpu_cachevalid,
    output logic                 sdram_req,
    output logic [ADDR_BITS-1:0] sdram_addr,
    input  logic                 sdram_fill,
    input  logic [15:0]          data_from_sdram
);

    localparam int WORDS     = 1 << BURST_LOG2;
    localparam int SETS      = 1 << SET_BITS;
    localparam int SET_LSB   = 1 + BURST_LOG2;
    localparam int TAG_LSB   = SET_LSB + SET_BITS;
    localparam int TAG_BITS  = ADDR_BITS - TAG_LSB;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int IDX_BITS  = SET_BITS + BURST_LOG2;
    localparam logic [BURST_LOG2-1:0] LAST_WORD = BURST_LOG2'(WORDS - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_WRITE, S_MISS, S_FILL, S_PAUSE
    } state_t;

    state_t state;

    // Storage: word data and byte-valids per word, tag and line-valid per line,
    // round-robin pointer per set. Byte-valids are kept as one vector per line so a
    // new allocation can clear every word of the line in a single cycle.
    logic [15:0]           data_mem [WAYS][SETS*WORDS];
    logic [2*WORDS-1:0]    bv_mem   [WAYS][SETS];
    logic [TAG_BITS-1:0]   tag_mem  [WAYS][SETS];
    logic                  lv_mem   [WAYS][SETS];
    logic [WAY_BITS-1:0]   rr_mem   [SETS];

    // Registered array outputs for the address presented in the previous cycle
    logic [15:0]           rd_data [WAYS];
    logic [2*WORDS-1:0]    rd_bv   [WAYS];
    logic [TAG_BITS-1:0]   rd_tag  [WAYS];
    logic [WAYS-1:0]       rd_lv;
    logic [WAY_BITS-1:0]   rd_rr;
    logic [BURST_LOG2-1:0] rd_word;

    // Access context latched at LOOKUP
    logic [SET_BITS-1:0]   lat_set;
    logic [BURST_LOG2-1:0] lat_word;
    logic [15:0]           lat_data;
    logic [1:0]            lat_be;
    logic [WAYS-1:0]       hit_mask;
    logic [WAY_BITS-1:0]   victim_q;
    logic [BURST_LOG2-1:0] fill_cnt;
    logic [IDX_BITS-1:0]   init_cnt;
    logic                  flush_pend;

    logic [SET_BITS-1:0]   cur_set;
    logic [BURST_LOG2-1:0] cur_word;
    logic [TAG_BITS-1:0]   cur_tag;
    logic [SET_BITS-1:0]   init_set;
    logic [IDX_BITS-1:0]   lat_idx;

    assign cur_set  = cpu_addr[TAG_LSB-1:SET_LSB];
    assign cur_word = cpu_addr[SET_LSB-1:1];
    assign cur_tag  = cpu_addr[ADDR_BITS-1:TAG_LSB];
    assign init_set = init_cnt[IDX_BITS-1:BURST_LOG2];
    assign lat_idx  = {lat_set, lat_word};

    logic [WAYS-1:0]     line_hit;
    logic [WAYS-1:0]     word_hit;
    logic                hit_any;
    logic [15:0]         hit_data;
    logic [WAY_BITS-1:0] victim;
    logic                use_rr;
    logic [WAY_BITS-1:0] next_rr;

    // Tag compare and victim choice on the registered array outputs
    // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        line_hit = '0;
        word_hit = '0;
        hit_data = '0;
        victim   = (WAYS > 1) ? rd_rr : '0;
        use_rr   = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            line_hit[w] = rd_lv[w] && (rd_tag[w] == cur_tag);
            word_hit[w] = line_hit[w] && (rd_bv[w][{rd_word, 1'b0} +: 2] == 2'b11);
        end
        // Scanning downwards lets the lowest matching way win
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (word_hit[w]) hit_data = rd_data[w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rd_lv[w]) begin
                victim = WAY_BITS'(w);
                use_rr = 1'b0;
            end
        end
        // A stale copy of the line takes precedence over an empty way
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (line_hit[w]) begin
                victim = WAY_BITS'(w);
                use_rr = 1'b0;
            end
        end
        hit_any = |word_hit;
        next_rr = (WAYS > 1) ? WAY_BITS'(victim + 1'b1) : '0;
    end

    // Hit indication is meaningless while the arrays are being swept or filled
    assign cpu_cachevalid = (state != S_INIT) && (state != S_MISS) &&
                            (state != S_FILL) && hit_any;

    // Synchronous array read for the address currently on the CPU bus
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            rd_data[w] <= data_mem[w][{cur_set, cur_word}];
            rd_bv[w]   <= bv_mem[w][cur_set];
            rd_tag[w]  <= tag_mem[w][cur_set];
            rd_lv[w]   <= lv_mem[w][cur_set];
        end
        rd_rr   <= rr_mem[cur_set];
        rd_word <= cur_word;
    end

    // Array updates: sweep clear, allocation, write-hit merge, line fill
    // NOTE: the arrays have no reset; the INIT sweep that follows every reset clears all valid state before any lookup.
    always_ff @(posedge clk) begin
        case (state)
            S_INIT: begin
                for (int w = 0; w < WAYS; w++) begin
                    lv_mem[w][init_set] <= 1'b0;
                    bv_mem[w][init_set] <= '0;
                end
                rr_mem[init_set] <= '0;
            end
            S_LOOKUP: begin
                if (cpu_rw_n && !hit_any) begin
                    tag_mem[victim][cur_set] <= cur_tag;
                    lv_mem[victim][cur_set]  <= 1'b1;
                    bv_mem[victim][cur_set]  <= '0;
                    if (WAYS > 1 && use_rr) rr_mem[cur_set] <= next_rr;
                end
            end
            S_WRITE: begin
                for (int w = 0; w < WAYS; w++) begin
                    if (hit_mask[w]) begin
                        if (lat_be[1]) data_mem[w][lat_idx][15:8] <= lat_data[15:8];
                        if (lat_be[0]) data_mem[w][lat_idx][7:0]  <= lat_data[7:0];
                        bv_mem[w][lat_set][{lat_word, 1'b0} +: 2] <=
                            bv_mem[w][lat_set][{lat_word, 1'b0} +: 2] | lat_be;
                    end
                end
            end
            S_MISS, S_FILL: begin
                if (sdram_fill) begin
                    data_mem[victim_q][lat_idx] <= data_from_sdram;
                    bv_mem[victim_q][lat_set][{lat_word, 1'b0} +: 2] <= 2'b11;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with registered bus outputs
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_INIT;
            ready       <= 1'b0;
            cpu_ack     <= 1'b0;
            data_to_cpu <= '0;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            lat_set     <= '0;
            lat_word    <= '0;
            lat_data    <= '0;
            lat_be      <= '0;
            hit_mask    <= '0;
            victim_q    <= '0;
            fill_cnt    <= '0;
            init_cnt    <= '0;
            flush_pend  <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            if (flush) flush_pend <= 1'b1;
            case (state)
                S_INIT: begin
                    ready <= 1'b0;
                    if (flush) begin
                        init_cnt   <= '0;
                        flush_pend <= 1'b0;
                    end else if (init_cnt == '1) begin
                        init_cnt <= '0;
                        ready    <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        init_cnt   <= '0;
                        ready      <= 1'b0;
                        state      <= S_INIT;
                    end else if (cpu_req) begin
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    lat_set  <= cur_set;
                    lat_word <= cur_word;
                    lat_data <= data_from_cpu;
                    lat_be   <= {~cpu_rwu_n, ~cpu_rwl_n};
                    hit_mask <= line_hit;
                    if (!cpu_rw_n) begin
                        cpu_ack <= 1'b1;
                        state   <= S_WRITE;
                    end else if (hit_any) begin
                        data_to_cpu <= hit_data;
                        cpu_ack     <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        victim_q   <= victim;
                        sdram_addr <= cpu_addr & ~ADDR_BITS'(1);
                        sdram_req  <= 1'b1;
                        state      <= S_MISS;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                S_MISS: begin
                    if (sdram_fill) begin
                        sdram_req   <= 1'b0;
                        data_to_cpu <= data_from_sdram;
                        lat_word    <= lat_word + 1'b1;
                        fill_cnt    <= BURST_LOG2'(1);
                        state       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (sdram_fill) begin
                        lat_word <= lat_word + 1'b1;
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == LAST_WORD) begin
                            cpu_ack <= 1'b1;
                            state   <= S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    state <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache with default parameters (2 ways, 256 sets, 4-word lines).
// A line-level behavioural model plus an SDRAM content function supply every expected value.
module tb_assoc_cache;

    localparam int WAYS  = 2;
    localparam int SETS  = 256;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready;
    logic        flush = 1'b0;
    logic [25:0] cpu_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw_n = 1'b1;
    logic        cpu_rwu_n = 1'b1;
    logic        cpu_rwl_n = 1'b1;
    logic [15:0] data_from_cpu = '0;
    logic [15:0] data_to_cpu;
    logic        cpu_ack;
    logic        cpu_cachevalid;
    logic        sdram_req;
    logic [25:0] sdram_addr;
    logic        sdram_fill = 1'b0;
    logic [15:0] data_from_sdram = '0;

    int n_vec = 0;
    int n_mis = 0;

    assoc_cache dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .flush(flush),
        .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_rw_n(cpu_rw_n),
        .cpu_rwu_n(cpu_rwu_n), .cpu_rwl_n(cpu_rwl_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .cpu_ack(cpu_ack), .cpu_cachevalid(cpu_cachevalid),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_fill(sdram_fill),
        .data_from_sdram(data_from_sdram)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SDRAM contents ----------------
    logic [15:0] ovr [int];

    function automatic logic [15:0] sdram_word(input int addr);
        int key;
        key = addr & ~1;
        if (ovr.exists(key)) return ovr[key];
        return 16'((key * 40503) ^ (key >>> 7) ^ 16'h3C5A);
    endfunction

    // ---------------- behavioural cache model ----------------
    bit          m_valid [WAYS][SETS];
    int          m_tag   [WAYS][SETS];
    logic [15:0] m_data  [WAYS][SETS][WORDS];
    bit   [1:0]  m_bv    [WAYS][SETS][WORDS];
    int          m_rr    [SETS];

    function automatic int a_set(input int a);  return (a >> 3) & (SETS - 1); endfunction
    function automatic int a_word(input int a); return (a >> 1) & (WORDS - 1); endfunction
    function automatic int a_tag(input int a);  return a >> 11; endfunction

    function automatic void model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 0;
                for (int k = 0; k < WORDS; k++) m_bv[w][s][k] = 2'b00;
            end
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    endfunction

    function automatic void model_read(input int a, output bit hit, output logic [15:0] d);
        int s, k;
        s = a_set(a); k = a_word(a);
        hit = 0; d = sdram_word(a);
        for (int w = WAYS - 1; w >= 0; w--)
            if (m_valid[w][s] && m_tag[w][s] == a_tag(a) && m_bv[w][s][k] == 2'b11) begin
                hit = 1; d = m_data[w][s][k];
            end
    endfunction

    function automatic void model_fill(input int a);
        int s, v;
        bit found;
        s = a_set(a); found = 0; v = 0;
        for (int w = 0; w < WAYS && !found; w++)
            if (m_valid[w][s] && m_tag[w][s] == a_tag(a)) begin v = w; found = 1; end
        for (int w = 0; w < WAYS && !found; w++)
            if (!m_valid[w][s]) begin v = w; found = 1; end
        if (!found) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_valid[v][s] = 1;
        m_tag[v][s] = a_tag(a);
        for (int k = 0; k < WORDS; k++) begin
            m_data[v][s][k] = sdram_word((a & ~7) + 2 * k);
            m_bv[v][s][k] = 2'b11;
        end
    endfunction

    function automatic void model_write(input int a, input bit up, input bit lo, input logic [15:0] d);
        int s, k;
        s = a_set(a); k = a_word(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][s] && m_tag[w][s] == a_tag(a)) begin
                if (up) begin m_data[w][s][k][15:8] = d[15:8]; m_bv[w][s][k][1] = 1'b1; end
                if (lo) begin m_data[w][s][k][7:0] = d[7:0];   m_bv[w][s][k][0] = 1'b1; end
            end
    endfunction

    // ---------------- per-cycle protocol checks ----------------
    bit prev_ack = 0;
    always @(negedge clk) begin
        if (reset_n && cpu_ack) check("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
        if (reset_n && !ready) check("cachevalid_in_sweep", {31'b0, cpu_cachevalid}, 32'd0);
        prev_ack = cpu_ack;
    end

    // ---------------- transaction tasks ----------------
    // Read with optional literal pins; flush_word >= 0 pulses flush during that fill beat.
    task automatic do_read(input int a, input int fill_delay, input int flush_word,
                           input bit lit_hit_en, input bit lit_hit,
                           input bit lit_data_en, input logic [15:0] lit_data,
                           input string name);
        bit exp_hit;
        logic [15:0] exp_data, first;
        int start;
        model_read(a, exp_hit, exp_data);
        @(negedge clk);
        cpu_addr = 26'(a); cpu_rw_n = 1'b1; cpu_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check({name, "_ack_t2"}, {31'b0, cpu_ack}, {31'b0, exp_hit});
        check({name, "_req_t2"}, {31'b0, sdram_req}, {31'b0, !exp_hit});
        if (lit_hit_en) check({name, "_lit_hit"}, {31'b0, cpu_ack}, {31'b0, lit_hit});
        if (cpu_ack) begin
            cpu_req = 1'b0;
            check({name, "_data"}, {16'b0, data_to_cpu}, {16'b0, exp_data});
            if (lit_data_en) check({name, "_lit_data"}, {16'b0, data_to_cpu}, {16'b0, lit_data});
            @(posedge clk); #1;
            check({name, "_ack_drop"}, {31'b0, cpu_ack}, 32'd0);
        end else if (sdram_req) begin
            check({name, "_sdram_addr"}, {6'b0, sdram_addr}, 32'(a & ~1));
            for (int d = 0; d < fill_delay; d++) begin
                @(posedge clk); #1;
                check({name, "_req_held"}, {31'b0, sdram_req}, 32'd1);
            end
            start = a_word(a);
            first = sdram_word(a);
            for (int i = 0; i < WORDS; i++) begin
                sdram_fill = 1'b1;
                data_from_sdram = sdram_word((a & ~7) + 2 * ((start + i) % WORDS));
                flush = (i == flush_word);
                @(posedge clk); #1;
                flush = 1'b0;
                if (i == 0) check({name, "_req_drop"}, {31'b0, sdram_req}, 32'd0);
                if (i < WORDS - 1) check({name, "_ack_early"}, {31'b0, cpu_ack}, 32'd0);
            end
            sdram_fill = 1'b0;
            check({name, "_fill_ack"}, {31'b0, cpu_ack}, 32'd1);
            check({name, "_fill_data"}, {16'b0, data_to_cpu}, {16'b0, first});
            if (lit_data_en) check({name, "_lit_data"}, {16'b0, data_to_cpu}, {16'b0, lit_data});
            cpu_req = 1'b0;
            if (!exp_hit) model_fill(a);
            @(posedge clk); #1;
            check({name, "_ack_drop"}, {31'b0, cpu_ack}, 32'd0);
        end else begin
            cpu_req = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input int a, input bit up, input bit lo, input logic [15:0] d,
                            input string name);
        @(negedge clk);
        cpu_addr = 26'(a); cpu_rw_n = 1'b0; cpu_rwu_n = !up; cpu_rwl_n = !lo;
        data_from_cpu = d; cpu_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check({name, "_ack_t2"}, {31'b0, cpu_ack}, 32'd1);
        check({name, "_no_fill"}, {31'b0, sdram_req}, 32'd0);
        cpu_req = 1'b0; cpu_rw_n = 1'b1; cpu_rwu_n = 1'b1; cpu_rwl_n = 1'b1;
        model_write(a, up, lo, d);
        @(posedge clk); #1;
        check({name, "_ack_drop"}, {31'b0, cpu_ack}, 32'd0);
    endtask

    task automatic check_cv(input int a, input string name);
        bit h;
        logic [15:0] d;
        model_read(a, h, d);
        @(negedge clk);
        cpu_addr = 26'(a); cpu_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check(name, {31'b0, cpu_cachevalid}, {31'b0, h});
    endtask

    // Count edges from reset release until ready rises
    task automatic release_and_count(input string name);
        int n;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
        end
        check(name, 32'(n), 32'd1024);
        model_clear();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bit seen;
        model_clear();
        // Line 0x100..0x107: critical word 0x104 gets A, then B, C, D in send order
        ovr[32'h104] = 16'h1234;
        ovr[32'h106] = 16'hBBBB;
        ovr[32'h100] = 16'hCCCC;
        ovr[32'h102] = 16'hD00D;

        // 1: reset state and init sweep length
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_ack", {31'b0, cpu_ack}, 32'd0);
        check("rst_sdram_req", {31'b0, sdram_req}, 32'd0);
        check("rst_data", {16'b0, data_to_cpu}, 32'd0);
        check("rst_sdram_addr", {6'b0, sdram_addr}, 32'd0);
        release_and_count("init_sweep_len");
        check_cv(32'h100, "cv_after_init");

        // 2: miss with critical-word-first fill, then a hit in the same line
        do_read(32'h104, 2, -1, 1, 0, 1, 16'h1234, "rd104");
        check_cv(32'h104, "cv_104");
        do_read(32'h102, 0, -1, 1, 1, 1, 16'hD00D, "rd102");

        // 3: three lines in set 0, round-robin eviction of way 0
        do_read(32'h000000, 1, -1, 1, 0, 0, 16'h0, "rd000");
        do_read(32'h000800, 0, -1, 1, 0, 0, 16'h0, "rd800");
        do_read(32'h001000, 3, -1, 1, 0, 0, 16'h0, "rd1000");
        do_read(32'h000800, 0, -1, 1, 1, 0, 16'h0, "rd800_hit");
        do_read(32'h000000, 0, -1, 1, 0, 0, 16'h0, "rd000_evicted");

        // 4: byte write merge and non-allocating write miss
        do_write(32'h104, 0, 1, 16'h00AA, "wr104_lo");
        do_read(32'h104, 0, -1, 1, 1, 1, 16'h12AA, "rd104_merged");
        do_read(32'h106, 0, -1, 1, 1, 1, 16'hBBBB, "rd106_kept");
        do_write(32'h7F0000, 1, 1, 16'hBEEF, "wr_miss");
        do_read(32'h7F0000, 0, -1, 1, 0, 0, 16'h0, "rd7f_no_alloc");
        // Wrap of the fill order from the last word of a line
        do_read(32'h1FE, 1, -1, 1, 0, 0, 16'h0, "rd1fe_wrap");
        do_read(32'h1F8, 0, -1, 1, 1, 0, 16'h0, "rd1f8_hit");

        // 5: flush during FILL completes the access, then a full sweep
        do_read(32'h2004, 0, 1, 1, 0, 0, 16'h0, "rd2004_flush");
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!ready) n++;
            else if (n > 0) break;
        end
        check("flush_sweep_len", 32'(n), 32'd1024);
        model_clear();
        do_read(32'h104, 0, -1, 1, 0, 0, 16'h0, "rd104_after_flush");

        // 6: reset during the third fill beat aborts at once
        @(negedge clk);
        cpu_addr = 26'h3000; cpu_rw_n = 1'b1; cpu_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("rd3000_req", {31'b0, sdram_req}, 32'd1);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            sdram_fill = 1'b1;
            data_from_sdram = sdram_word(32'h3000 + 2 * i);
            if (i == 2) begin
                #3;
                reset_n = 1'b0;
                #1;
                check("abort_sdram_req", {31'b0, sdram_req}, 32'd0);
                check("abort_ready", {31'b0, ready}, 32'd0);
                seen = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("abort_reached", {31'b0, seen}, 32'd1);
        sdram_fill = 1'b0; cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        release_and_count("abort_sweep_len");
        do_read(32'h3000, 0, -1, 1, 0, 0, 16'h0, "rd3000_after_rst");
        do_read(32'h000800, 0, -1, 1, 0, 0, 16'h0, "rd800_after_rst");
        do_read(32'h3000, 0, -1, 1, 1, 0, 16'h0, "rd3000_refill_hit");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
